// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: turns debounced key events into wall-checked player steps on a bounded grid.
// Optional request timeout enabled by defining MAZE_MOVE_TIMEOUT_EN.
module maze_move_ctrl #(
    parameter int X_W     = 4,
    parameter int Y_W     = 4,
    parameter int X_MAX   = 15,
    parameter int Y_MAX   = 15,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    input  logic           i_fKey,
    input  logic [3:0]     i_Key,
    output logic           o_MapReq,
    output logic [X_W-1:0] o_MapX,
    output logic [Y_W-1:0] o_MapY,
    input  logic           i_MapAck,
    input  logic           i_MapWall,
    output logic [X_W-1:0] o_PosX,
    output logic [Y_W-1:0] o_PosY,
    output logic           o_fMoved,
    output logic           o_fBump,
    output logic           o_fGoal,
    output logic           o_Busy,
    output logic [15:0]    o_MoveCnt
);
    localparam logic [1:0]     S_IDLE = 2'd0;
    localparam logic [1:0]     S_REQ  = 2'd1;
    localparam logic [1:0]     S_GOAL = 2'd2;
    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(Y_MAX);
    localparam logic [X_W:0]   X_ONE  = (X_W+1)'(1);
    localparam logic [Y_W:0]   Y_ONE  = (Y_W+1)'(1);
    localparam logic [X_W-1:0] X_ST   = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_ST   = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_GL   = X_W'(GOAL_X);
    localparam logic [Y_W-1:0] Y_GL   = Y_W'(GOAL_Y);

    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] pos_x_q, pos_x_d, map_x_q, map_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d, map_y_q, map_y_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           req_q, req_d, busy_q, busy_d, goal_q, goal_d;
    logic           moved_q, moved_d, bump_q, bump_d;
    logic [X_W:0]   tx;
    logic [Y_W:0]   ty;
    logic           in_rng;
`ifdef MAZE_MOVE_TIMEOUT_EN
    logic [4:0]     to_q, to_d;
`endif

    // one extra bit on each axis so a step past 0 wraps to a value above the limit
    always_comb begin
        tx     = i_Key[3] ? {1'b0, pos_x_q} + X_ONE : i_Key[2] ? {1'b0, pos_x_q} - X_ONE : {1'b0, pos_x_q};
        ty     = i_Key[1] ? {1'b0, pos_y_q} + Y_ONE : i_Key[0] ? {1'b0, pos_y_q} - Y_ONE : {1'b0, pos_y_q};
        in_rng = (tx <= X_LIM) && (ty <= Y_LIM);
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        map_x_d = map_x_q;
        map_y_d = map_y_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        goal_d  = goal_q;
        moved_d = 1'b0;
        bump_d  = 1'b0;
`ifdef MAZE_MOVE_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_fKey && $onehot(i_Key)) begin
                    if (in_rng) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        map_x_d = tx[X_W-1:0];
                        map_y_d = ty[Y_W-1:0];
`ifdef MAZE_MOVE_TIMEOUT_EN
                        to_d    = 5'd0;
`endif
                    end else begin
                        bump_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (i_MapAck) begin
                    req_d  = 1'b0;
                    busy_d = 1'b0;
                    if (i_MapWall) begin
                        bump_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pos_x_d = map_x_q;
                        pos_y_d = map_y_q;
                        moved_d = 1'b1;
                        cnt_d   = cnt_q + {15'd0, cnt_q != 16'hFFFF};
                        goal_d  = (map_x_q == X_GL) && (map_y_q == Y_GL);
                        state_d = goal_d ? S_GOAL : S_IDLE;
                    end
                end
`ifdef MAZE_MOVE_TIMEOUT_EN
                else if (to_q == 5'd30) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    bump_d  = 1'b1;
                    to_d    = 5'd31;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 5'd1;
                end
`endif
            end
            S_GOAL: goal_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            pos_x_q <= X_ST;
            pos_y_q <= Y_ST;
            map_x_q <= '0;
            map_y_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            goal_q  <= 1'b0;
            moved_q <= 1'b0;
            bump_q  <= 1'b0;
`ifdef MAZE_MOVE_TIMEOUT_EN
            to_q    <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            map_x_q <= map_x_d;
            map_y_q <= map_y_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            goal_q  <= goal_d;
            moved_q <= moved_d;
            bump_q  <= bump_d;
`ifdef MAZE_MOVE_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign o_MapReq  = req_q;
    assign o_MapX    = map_x_q;
    assign o_MapY    = map_y_q;
    assign o_PosX    = pos_x_q;
    assign o_PosY    = pos_y_q;
    assign o_fMoved  = moved_q;
    assign o_fBump   = bump_q;
    assign o_fGoal   = goal_q;
    assign o_Busy    = busy_q;
    assign o_MoveCnt = cnt_q;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: checks maze_move_ctrl against a position/count model on a 16x16 grid with goal (1,1).
module tb_maze_move_ctrl;
    localparam int GX = 1;
    localparam int GY = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fkey = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        ack = 1'b0;
    logic        wall = 1'b0;
    logic        map_req, moved, bump, goal, busy;
    logic [3:0]  map_x, map_y, pos_x, pos_y;
    logic [15:0] move_cnt;

    int tests = 0;
    int fails = 0;
    int mx = 0, my = 0, mc = 0;
    bit mg = 1'b0;

    always #5 clk = ~clk;

    maze_move_ctrl #(.GOAL_X(GX), .GOAL_Y(GY)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_fKey(fkey), .i_Key(key),
        .o_MapReq(map_req), .o_MapX(map_x), .o_MapY(map_y),
        .i_MapAck(ack), .i_MapWall(wall),
        .o_PosX(pos_x), .o_PosY(pos_y), .o_fMoved(moved), .o_fBump(bump),
        .o_fGoal(goal), .o_Busy(busy), .o_MoveCnt(move_cnt)
    );

    // {req, busy, moved, bump, goal, x, y, count}
    function automatic logic [28:0] snap();
        return {map_req, busy, moved, bump, goal, pos_x, pos_y, move_cnt};
    endfunction

    function automatic logic [28:0] mk(input bit r, input bit b, input bit mv, input bit bp,
                                       input bit g, input int x, input int y, input int c);
        return {r, b, mv, bp, g, 4'(x), 4'(y), 16'(c)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mx = 0; my = 0; mc = 0; mg = 1'b0;
    endtask

    task automatic do_step(input logic [3:0] k, input int dly, input logic w, input bit drop, input string nm);
        int tx, ty;
        bit acc, rng;
        logic [28:0] obs, exp;
        acc = !mg && $countones(k) == 1;
        tx = mx + (k[3] ? 1 : 0) - (k[2] ? 1 : 0);
        ty = my + (k[1] ? 1 : 0) - (k[0] ? 1 : 0);
        rng = tx >= 0 && tx <= 15 && ty >= 0 && ty <= 15;
        @(negedge clk);
        fkey = 1'b1; key = k;
        @(negedge clk);
        fkey = 1'b0; key = 4'd0;
        obs = snap();
        exp = !acc ? mk(0, 0, 0, 0, mg, mx, my, mc) : !rng ? mk(0, 0, 0, 1, mg, mx, my, mc) : mk(1, 1, 0, 0, mg, mx, my, mc);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL %s accept: got %h want %h", nm, obs, exp); end
        if (acc && rng) begin
            for (int i = 0; i < dly; i++) begin
                tests++;
                if ({map_req, map_x, map_y} !== {1'b1, 4'(tx), 4'(ty)}) begin
                    fails++; $display("FAIL %s hold: got %h want %h", nm, {map_req, map_x, map_y}, {1'b1, 4'(tx), 4'(ty)});
                end
                if (drop && i == 0) begin fkey = 1'b1; key = 4'(1 << $urandom_range(0, 3)); end
                @(negedge clk);
                fkey = 1'b0; key = 4'd0;
            end
            tests++;
            if ({map_req, map_x, map_y} !== {1'b1, 4'(tx), 4'(ty)}) begin
                fails++; $display("FAIL %s target: got %h want %h", nm, {map_req, map_x, map_y}, {1'b1, 4'(tx), 4'(ty)});
            end
            ack = 1'b1; wall = w;
            @(negedge clk);
            ack = 1'b0; wall = 1'b0;
            if (!w) begin mx = tx; my = ty; mc++; mg = (mx == GX && my == GY); end
            obs = snap();
            exp = mk(0, 0, !w, w, mg, mx, my, mc);
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL %s done: got %h want %h", nm, obs, exp); end
        end
        @(negedge clk);
        obs = snap();
        exp = mk(0, 0, 0, 0, mg, mx, my, mc);
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL %s idle: got %h want %h", nm, obs, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({snap(), map_x, map_y} !== {mk(0, 0, 0, 0, 0, 0, 0, 0), 8'd0}) begin
            fails++; $display("FAIL reset: got %h want %h", {snap(), map_x, map_y}, {mk(0, 0, 0, 0, 0, 0, 0, 0), 8'd0});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_step(4'b1000, 0, 1'b0, 1'b0, "first_right");
        do_reset();
        do_step(4'b0001, 0, 1'b0, 1'b0, "up_bound");
        do_step(4'b1000, 0, 1'b0, 1'b0, "right_again");
        do_step(4'b0010, 5, 1'b1, 1'b0, "wall_delay");
    endtask

    task automatic test_invalid_and_drop();
        do_step(4'b0101, 0, 1'b0, 1'b0, "two_bits");
        do_step(4'b0000, 0, 1'b0, 1'b0, "no_bits");
        do_step(4'b1111, 0, 1'b0, 1'b0, "all_bits");
        do_step(4'b1000, 3, 1'b0, 1'b1, "drop_in_req");
    endtask

    task automatic test_goal();
        do_reset();
        do_step(4'b1000, 0, 1'b0, 1'b0, "goal_right");
        do_step(4'b0010, 1, 1'b0, 1'b0, "goal_down");
        do_step(4'b0001, 0, 1'b0, 1'b0, "goal_ignore_up");
        do_step(4'b0100, 0, 1'b0, 1'b0, "goal_ignore_left");
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mx = 0; my = 0; mc = 0; mg = 1'b0;
        fkey = 1'b1; key = 4'b1000;
        @(negedge clk);
        fkey = 1'b0; key = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        tests++;
        if ({snap(), map_x, map_y} !== {mk(0, 0, 0, 0, 0, 0, 0, 0), 8'd0}) begin
            fails++; $display("FAIL mid_req_reset: got %h want %h", {snap(), map_x, map_y}, {mk(0, 0, 0, 0, 0, 0, 0, 0), 8'd0});
        end
    endtask

    task automatic test_edges();
        do_reset();
        for (int i = 0; i < 15; i++) do_step(4'b1000, $urandom_range(0, 2), 1'b0, 1'b0, "walk_right");
        do_step(4'b1000, 0, 1'b0, 1'b0, "right_bound");
        do_step(4'b0001, 0, 1'b0, 1'b0, "up_bound_edge");
        for (int i = 0; i < 15; i++) do_step(4'b0010, 0, 1'b0, 1'b0, "walk_down");
        do_step(4'b0010, 0, 1'b0, 1'b0, "down_bound");
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        @(negedge clk);
        fkey = 1'b1; key = 4'b1000;
        @(negedge clk);
        fkey = 1'b0; key = 4'd0;
        n = 0;
        for (int i = 0; i < 120; i++) begin
            if (!map_req) break;
            n++;
            @(negedge clk);
        end
`ifdef MAZE_MOVE_TIMEOUT_EN
        tests++;
        if ({n, bump, pos_x, pos_y} !== {32'd31, 1'b1, 8'd0}) begin
            fails++; $display("FAIL timeout: got %0d/%b/%h want 31/1/00", n, bump, {pos_x, pos_y});
        end
`else
        tests++;
        if ({n, bump, busy} !== {32'd120, 1'b0, 1'b1}) begin
            fails++; $display("FAIL no_timeout: got %0d/%b/%b want 120/0/1", n, bump, busy);
        end
`endif
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0] k;
        int r;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            k = r < 8 ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
            do_step(k, $urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "random");
            if (mg) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_and_drop();
        test_goal();
        test_reset_mid_req();
        test_edges();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/maze_move_ctrl.md
Name: maze_move_ctrl

Overview:
- Consumer side of the debounced push-button interface. Takes the one-cycle key-event strobe and the 4-bit active-high key vector, then turns each accepted event into one player step in the maze.
- Checks every step against grid bounds and against the maze wall map, using a request/acknowledge lookup.
- Keeps the player position, move count and goal status for the display and game-control logic.

Parameters:
- X_W, 4, width of X coordinate
- Y_W, 4, width of Y coordinate
- X_MAX, 15, largest legal X
- Y_MAX, 15, largest legal Y
- START_X, 0, X position after reset
- START_Y, 0, Y position after reset
- GOAL_X, 15, X of goal cell
- GOAL_Y, 15, Y of goal cell

Ports:
- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst  input  1  synchronous reset, active-high
- i_fKey  input  1  key-event strobe, one cycle wide
- i_Key  input  4  key vector, active-high, valid with i_fKey: bit0 up (Y-1), bit1 down (Y+1), bit2 left (X-1), bit3 right (X+1)
- o_MapReq  output  1  wall lookup request
- o_MapX  output  X_W  lookup target X; stable while o_MapReq=1
- o_MapY  output  Y_W  lookup target Y; stable while o_MapReq=1
- i_MapAck  input  1  lookup done; sampled only while o_MapReq=1
- i_MapWall  input  1  1 = target cell is a wall; valid with i_MapAck
- o_PosX  output  X_W  current player X
- o_PosY  output  Y_W  current player Y
- o_fMoved  output  1  one-cycle pulse when the position has changed
- o_fBump  output  1  one-cycle pulse when a step is rejected (bound, wall or timeout)
- o_fGoal  output  1  level; high while the player is on the goal cell
- o_Busy  output  1  high while a step is being processed
- o_MoveCnt  output  16  count of successful steps; saturates at 16'hFFFF

Behaviour:
- Synchronous reset (i_Rst=1 at a rising edge) forces all of the following, including in the middle of a lookup. The aborted request is not completed, and a late i_MapAck after reset is ignored.
  - state = IDLE
  - o_PosX/o_PosY = START_X/START_Y
  - o_MoveCnt = 0
  - o_MapReq = 0, o_MapX = 0, o_MapY = 0
  - o_fMoved, o_fBump, o_fGoal, o_Busy = 0
  - timeout counter = 0
- States: IDLE, REQ, GOAL. All outputs are registered.
- IDLE:
  - Event accepted only when i_fKey=1 and i_Key has exactly one bit set. Zero or multiple bits set: event ignored, no pulse.
  - Target = current position +/- 1 on one axis. Arithmetic uses an extra bit so underflow and overflow are detectable.
  - Target outside 0..X_MAX or 0..Y_MAX: o_fBump=1 next cycle, stay in IDLE, no lookup.
  - Target in range: next cycle o_MapReq=1, o_MapX/o_MapY=target, o_Busy=1, state=REQ.
- REQ:
  - o_MapReq, o_MapX and o_MapY are held until a cycle with i_MapAck=1. In the cycle after that, o_MapReq=0 and o_Busy=0.
  - i_MapWall=1 at ack: o_fBump=1 for one cycle, position unchanged, back to IDLE.
  - i_MapWall=0 at ack: o_PosX/o_PosY = target, o_fMoved=1 for one cycle, o_MoveCnt += 1 (saturating).
    - New position == (GOAL_X, GOAL_Y): state=GOAL and o_fGoal=1 in the same cycle as o_fMoved.
    - Otherwise: back to IDLE.
  - i_fKey during REQ is dropped, not queued.
  - Earliest ack is in the first cycle of o_MapReq=1, giving 2-cycle latency from the i_fKey edge to o_fMoved.
- GOAL: terminal state.
  - o_fGoal stays 1.
  - All key events are ignored.
  - Exited only by reset.
- START on the goal cell: a legal configuration. The FSM still starts in IDLE, and o_fGoal asserts only after a move into the goal cell.

Optional Feature:
- Macro: MAZE_MOVE_TIMEOUT_EN.
- Defined:
  - A 5-bit counter clears on entry to REQ and increments every REQ cycle without an ack.
  - When it reaches 31, the request is abandoned: o_MapReq=0, o_fBump=1 for one cycle, position unchanged, back to IDLE.
  - If ack and timeout occur in the same cycle, the ack wins.
- Not defined: REQ waits indefinitely for i_MapAck, and no counter logic exists.

Test Plan:
- Reset, then i_fKey=1 with i_Key=4'b1000 and ack with wall=0 in the first REQ cycle -> o_PosX=1, o_PosY=0, o_fMoved pulse 2 cycles after the strobe, o_MoveCnt=1.
- From (0,0), i_Key=4'b0001 (up) -> o_fBump next cycle, o_MapReq never asserts, position stays (0,0).
- From (1,0), i_Key=4'b0010 with ack delayed 5 cycles and wall=1 -> o_MapX=1 and o_MapY=1 held for 5 cycles, then o_fBump, position unchanged, o_MoveCnt unchanged.
- i_Key=4'b0101, and i_Key=4'b0000 with a strobe -> no request, no pulses. A second strobe during REQ -> dropped, exactly one step occurs.
- With GOAL=(1,1), path right then down -> o_fGoal=1 with the second o_fMoved. Later key events are ignored. Reset asserted mid-REQ -> position=(0,0), o_MapReq=0, o_fGoal=0.
- With MAZE_MOVE_TIMEOUT_EN defined and no ack -> o_fBump after 31 REQ cycles, o_MapReq drops. Without the macro, o_MapReq stays high for 100+ cycles.
